// File: rtl/oflow_similarity_dispatcher.sv
// oflow_similarity_dispatcher
// Walks the previous-frame feature table for one current object, launches one
// similarity-metric computation per entry and keeps the minimum-score match.
// Optional build macro: OFLOW_SIM_DISPATCH_TIMEOUT_EN adds a per-entry WAIT
// timeout and a sticky timeout_err output.
module oflow_similarity_dispatcher #(
  parameter int MAX_PREV  = 32,
  parameter int ADDR_LEN  = 5,
  parameter int FEAT_LEN  = 128,
  parameter int SCORE_LEN = 32,
  parameter int ID_LEN    = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset_N,
  input  logic                 start,
  input  logic [ADDR_LEN:0]    num_prev,
  input  logic [SCORE_LEN-1:0] threshold,
  output logic                 rd_en,
  output logic [ADDR_LEN-1:0]  rd_addr,
  input  logic [FEAT_LEN-1:0]  rd_data,
  output logic                 sm_start,
  output logic [FEAT_LEN-1:0]  sm_features_of_prev,
  input  logic                 sm_valid,
  input  logic [SCORE_LEN-1:0] sm_score,
  input  logic [ID_LEN-1:0]    sm_id,
  output logic                 busy,
  output logic                 done,
  output logic [SCORE_LEN-1:0] best_score,
  output logic [ID_LEN-1:0]    best_id,
  output logic                 match_valid
`ifdef OFLOW_SIM_DISPATCH_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LOAD, S_ISSUE, S_WAIT, S_CMP, S_FINISH
  } state_t;

  localparam logic [ADDR_LEN:0] ONE_IDX = (ADDR_LEN+1)'(1);

  state_t                 state_q, state_d;
  logic [ADDR_LEN:0]      idx_q, idx_d;
  logic [ADDR_LEN:0]      num_q, num_d;
  logic [SCORE_LEN-1:0]   thr_q, thr_d;
  logic [SCORE_LEN-1:0]   cap_score_q, cap_score_d;
  logic [ID_LEN-1:0]      cap_id_q, cap_id_d;
  logic [FEAT_LEN-1:0]    feat_q, feat_d;
  logic                   rd_en_q, rd_en_d;
  logic [ADDR_LEN-1:0]    rd_addr_q, rd_addr_d;
  logic                   sm_start_q, sm_start_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [SCORE_LEN-1:0]   best_score_q, best_score_d;
  logic [ID_LEN-1:0]      best_id_q, best_id_d;
  logic                   match_valid_q, match_valid_d;

`ifdef OFLOW_SIM_DISPATCH_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT + 1);
  logic [WCW-1:0]         wait_cnt_q, wait_cnt_d;
  logic                   timeout_err_q, timeout_err_d;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  // Next-state and datapath logic; outputs are derived from the next state so
  // they come straight out of flops and line up with the state they describe.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    num_d         = num_q;
    thr_d         = thr_q;
    cap_score_d   = cap_score_q;
    cap_id_d      = cap_id_q;
    feat_d        = feat_q;
    rd_addr_d     = rd_addr_q;
    best_score_d  = best_score_q;
    best_id_d     = best_id_q;
    match_valid_d = match_valid_q;
`ifdef OFLOW_SIM_DISPATCH_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d         = num_prev;
          thr_d         = threshold;
          idx_d         = '0;
          best_score_d  = '1;
          best_id_d     = '1;
          match_valid_d = 1'b0;
`ifdef OFLOW_SIM_DISPATCH_TIMEOUT_EN
          timeout_err_d = 1'b0;
`endif
          state_d = (num_prev != '0) ? S_READ : S_FINISH;
        end
      end
      S_READ:  state_d = S_LOAD;
      S_LOAD: begin
        feat_d  = rd_data;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // Any sm_valid seen here belongs to nothing we launched; ignore it.
`ifdef OFLOW_SIM_DISPATCH_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (sm_valid) begin
          cap_score_d = sm_score;
          cap_id_d    = sm_id;
          state_d     = S_CMP;
        end
`ifdef OFLOW_SIM_DISPATCH_TIMEOUT_EN
        else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
          // An all-ones score can never be strictly below best, so the
          // skipped entry cannot win.
          cap_score_d   = '1;
          timeout_err_d = 1'b1;
          state_d       = S_CMP;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
`endif
      end
      S_CMP: begin
        // Strict compare: ties keep the earlier entry.
        if (cap_score_q < best_score_q) begin
          best_score_d = cap_score_q;
          best_id_d    = cap_id_q;
        end
        if (idx_q == num_q - ONE_IDX) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + ONE_IDX;
          state_d = S_READ;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    rd_en_d    = (state_d == S_READ);
    sm_start_d = (state_d == S_ISSUE);
    done_d     = (state_d == S_FINISH);
    busy_d     = (state_d != S_IDLE) && (state_d != S_FINISH);
    if (state_d == S_READ) begin
      rd_addr_d = idx_d[ADDR_LEN-1:0];
    end
    if (state_d == S_FINISH) begin
      match_valid_d = (best_score_d <= thr_d) && (num_d != '0);
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      num_q         <= '0;
      thr_q         <= '0;
      cap_score_q   <= '0;
      cap_id_q      <= '0;
      feat_q        <= '0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      sm_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      best_score_q  <= '1;
      best_id_q     <= '1;
      match_valid_q <= 1'b0;
`ifdef OFLOW_SIM_DISPATCH_TIMEOUT_EN
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      num_q         <= num_d;
      thr_q         <= thr_d;
      cap_score_q   <= cap_score_d;
      cap_id_q      <= cap_id_d;
      feat_q        <= feat_d;
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      sm_start_q    <= sm_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      best_score_q  <= best_score_d;
      best_id_q     <= best_id_d;
      match_valid_q <= match_valid_d;
`ifdef OFLOW_SIM_DISPATCH_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign rd_en               = rd_en_q;
  assign rd_addr             = rd_addr_q;
  assign sm_start            = sm_start_q;
  assign sm_features_of_prev = feat_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign best_score          = best_score_q;
  assign best_id             = best_id_q;
  assign match_valid         = match_valid_q;
`ifdef OFLOW_SIM_DISPATCH_TIMEOUT_EN
  assign timeout_err         = timeout_err_q;
`endif

endmodule

// File: tb/tb_oflow_similarity_dispatcher.sv
// Bench for oflow_similarity_dispatcher: feature RAM model, metric-unit model
// and a scoreboard of expected search results checked at each done pulse.
// Build with OFLOW_SIM_DISPATCH_TIMEOUT_EN to include the timeout scenario.
module tb_oflow_similarity_dispatcher;
  localparam int TIMEOUT = 64;

  logic         clk;
  logic         reset_N;
  logic         start;
  logic [5:0]   num_prev;
  logic [31:0]  threshold;
  logic         rd_en;
  logic [4:0]   rd_addr;
  logic [127:0] rd_data;
  logic         sm_start;
  logic [127:0] sm_features_of_prev;
  logic         sm_valid;
  logic [31:0]  sm_score;
  logic [7:0]   sm_id;
  logic         busy;
  logic         done;
  logic [31:0]  best_score;
  logic [7:0]   best_id;
  logic         match_valid;
`ifdef OFLOW_SIM_DISPATCH_TIMEOUT_EN
  logic         timeout_err;
`endif

  oflow_similarity_dispatcher #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_N(reset_N), .start(start), .num_prev(num_prev),
    .threshold(threshold), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .sm_start(sm_start), .sm_features_of_prev(sm_features_of_prev),
    .sm_valid(sm_valid), .sm_score(sm_score), .sm_id(sm_id), .busy(busy),
    .done(done), .best_score(best_score), .best_id(best_id),
    .match_valid(match_valid)
`ifdef OFLOW_SIM_DISPATCH_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] score;
    logic [7:0]  id;
    logic        mv;
    logic        terr;
    int          cyc;
    int          n;
  } exp_t;

  typedef struct {
    int          n;
    logic [31:0] thr;
    int          lat;
    logic        spur;
    logic [31:0] s0, s1, s2;
    logic [7:0]  i0, i1, i2;
    logic [31:0] es;
    logic [7:0]  ei;
    logic        emv;
  } vec_t;

  exp_t         sb_q[$];
  logic [127:0] feat_mem [32];
  logic [31:0]  sc [32];
  logic [7:0]   ids [32];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int lat = 1;
  int drop_idx = -1;
  logic spur = 1'b0;
  int rd_cnt = 0, sm_cnt = 0, exp_addr = 0;
  logic ram_pend = 1'b0;
  logic [4:0] ram_addr = '0;
  int rem = 0;
  logic inflight = 1'b0;
  logic [4:0] pend_addr = '0;
  logic [127:0] hold_feat = '0;
  logic [4:0] hold_addr = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle observation of DUT outputs, including the scoreboard at done.
  task automatic monitor();
    exp_t e;
    if (rd_en) begin
      chk("rd_addr_seq", 128'(rd_addr), 128'(exp_addr));
      exp_addr++;
      rd_cnt++;
    end
    if (inflight) begin
      chk("feat_stable_wait", sm_features_of_prev, hold_feat);
      chk("addr_stable_wait", 128'(rd_addr), 128'(hold_addr));
    end
    if (sm_start) begin
      sm_cnt++;
      chk("sm_features", sm_features_of_prev, feat_mem[rd_addr]);
    end
    if (sb_q.size() > 0 && cyc > start_cyc && cyc < sb_q[0].cyc)
      chk("busy_during_search", 128'(busy), 128'(1));
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending search (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("done_cycle", 128'(cyc), 128'(e.cyc));
        chk("best_score", 128'(best_score), 128'(e.score));
        chk("best_id", 128'(best_id), 128'(e.id));
        chk("match_valid", 128'(match_valid), 128'(e.mv));
        chk("busy_at_done", 128'(busy), 128'(0));
        chk("rd_en_count", 128'(rd_cnt), 128'(e.n));
        chk("sm_start_count", 128'(sm_cnt), 128'(e.n));
`ifdef OFLOW_SIM_DISPATCH_TIMEOUT_EN
        chk("timeout_err", 128'(timeout_err), 128'(e.terr));
`endif
      end
    end
  endtask

  // Feature RAM (one-cycle read latency) and metric unit (latency lat).
  task automatic drive_models();
    if (ram_pend) rd_data = feat_mem[ram_addr];
    else          rd_data = {$urandom, $urandom, $urandom, $urandom};
    ram_pend = rd_en && reset_N;
    ram_addr = rd_addr;

    sm_valid = 1'b0;
    sm_score = $urandom;
    sm_id    = 8'($urandom);
    if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        sm_valid = 1'b1;
        sm_score = sc[pend_addr];
        sm_id    = ids[pend_addr];
        inflight = 1'b0;
      end
    end
    if (sm_start && reset_N) begin
      pend_addr = rd_addr;
      hold_addr = rd_addr;
      hold_feat = sm_features_of_prev;
      if (int'(rd_addr) == drop_idx) begin
        rem = 0;
        inflight = 1'b0;
      end else begin
        rem = lat;
        inflight = 1'b1;
      end
      if (spur) begin
        sm_valid = 1'b1;
        sm_score = 32'd0;
        sm_id    = 8'hEE;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (reset_N) monitor();
    drive_models();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, 128'(rd_en), 128'(0));
    chk({tag, "_rd_addr"}, 128'(rd_addr), 128'(0));
    chk({tag, "_sm_start"}, 128'(sm_start), 128'(0));
    chk({tag, "_sm_features"}, sm_features_of_prev, 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_best_score"}, 128'(best_score), 128'(32'hFFFF_FFFF));
    chk({tag, "_best_id"}, 128'(best_id), 128'(8'hFF));
    chk({tag, "_match_valid"}, 128'(match_valid), 128'(0));
`ifdef OFLOW_SIM_DISPATCH_TIMEOUT_EN
    chk({tag, "_timeout_err"}, 128'(timeout_err), 128'(0));
`endif
  endtask

  // Push the expected result, pulse start, then wait (bounded) for done.
  task automatic run_search(input int n, input logic [31:0] thr, input int l,
                            input logic [31:0] es, input logic [7:0] ei,
                            input logic emv, input logic eterr, input int extra_at);
    exp_t e;
    int total;
    int budget;
    total = n * (4 + l) + 1;
    if (drop_idx >= 0 && drop_idx < n) total = total + TIMEOUT - l;
    budget = total + 20;
    lat = l;
    rd_cnt = 0;
    sm_cnt = 0;
    exp_addr = 0;
    start_cyc = cyc;
    e.score = es; e.id = ei; e.mv = emv; e.terr = eterr;
    e.cyc = cyc + total; e.n = n;
    sb_q.push_back(e);
    num_prev = 6'(n);
    threshold = thr;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < budget && sb_q.size() > 0; k++) begin
      if (k == extra_at) begin
        start = 1'b1;
        num_prev = 6'd1;
      end
      tick();
      start = 1'b0;
    end
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done within %0d cycles expected done at cycle %0d", budget, e.cyc);
      sb_q.delete();
    end
    tick();
    tick();
  endtask

  initial begin
    vec_t vecs[7];
    logic [31:0] m_best;
    logic [7:0]  m_id;

    reset_N = 1'b0; start = 1'b0; num_prev = '0; threshold = '0;
    rd_data = '0; sm_valid = 1'b0; sm_score = '0; sm_id = '0;
    for (int k = 0; k < 32; k++) begin
      feat_mem[k] = {$urandom, $urandom, $urandom, 32'(k)};
      sc[k] = 32'hFFFF_FFFF;
      ids[k] = 8'(k);
    end

    vecs[0] = '{n:3, thr:32'd250, lat:2, spur:1'b0, s0:32'd500, s1:32'd200, s2:32'd300,
                i0:8'd7, i1:8'd9, i2:8'd4, es:32'd200, ei:8'd9, emv:1'b1};
    vecs[1] = '{n:2, thr:32'd99, lat:1, spur:1'b0, s0:32'd100, s1:32'd100, s2:32'd0,
                i0:8'd1, i1:8'd2, i2:8'd0, es:32'd100, ei:8'd1, emv:1'b0};
    vecs[2] = '{n:2, thr:32'd100, lat:3, spur:1'b0, s0:32'd100, s1:32'd100, s2:32'd0,
                i0:8'd1, i1:8'd2, i2:8'd0, es:32'd100, ei:8'd1, emv:1'b1};
    vecs[3] = '{n:0, thr:32'hFFFF_FFFF, lat:1, spur:1'b0, s0:32'd0, s1:32'd0, s2:32'd0,
                i0:8'd0, i1:8'd0, i2:8'd0, es:32'hFFFF_FFFF, ei:8'hFF, emv:1'b0};
    vecs[4] = '{n:1, thr:32'd0, lat:1, spur:1'b0, s0:32'd0, s1:32'd0, s2:32'd0,
                i0:8'h55, i1:8'd0, i2:8'd0, es:32'd0, ei:8'h55, emv:1'b1};
    vecs[5] = '{n:3, thr:32'hFFFF_FFFF, lat:1, spur:1'b0, s0:32'hFFFF_FFFF,
                s1:32'hFFFF_FFFF, s2:32'hFFFF_FFFF, i0:8'd3, i1:8'd4, i2:8'd5,
                es:32'hFFFF_FFFF, ei:8'hFF, emv:1'b1};
    vecs[6] = '{n:3, thr:32'd150, lat:4, spur:1'b1, s0:32'd300, s1:32'd200, s2:32'd100,
                i0:8'd1, i1:8'd2, i2:8'd3, es:32'd100, ei:8'd3, emv:1'b1};

    tick();
    tick();
    check_reset_outputs("reset");
    reset_N = 1'b1;
    tick();
    tick();

    // Table-driven searches.
    for (int v = 0; v < 7; v++) begin
      sc[0] = vecs[v].s0; sc[1] = vecs[v].s1; sc[2] = vecs[v].s2;
      ids[0] = vecs[v].i0; ids[1] = vecs[v].i1; ids[2] = vecs[v].i2;
      spur = vecs[v].spur;
      run_search(vecs[v].n, vecs[v].thr, vecs[v].lat, vecs[v].es, vecs[v].ei,
                 vecs[v].emv, 1'b0, -1);
      spur = 1'b0;
    end

    // Full table, latency 10, a second start mid-search must be ignored.
    for (int k = 0; k < 32; k++) begin
      sc[k] = $urandom_range(100000, 1000);
      ids[k] = 8'(k + 32);
    end
    sc[17] = 32'd50;
    sc[25] = 32'd50;
    m_best = 32'hFFFF_FFFF;
    m_id = 8'hFF;
    for (int k = 0; k < 32; k++) begin
      if (sc[k] < m_best) begin
        m_best = sc[k];
        m_id = ids[k];
      end
    end
    run_search(32, 32'd50, 10, m_best, m_id, 1'b1, 1'b0, 50);

    // Reset asserted mid-WAIT aborts the search without a done pulse.
    sc[0] = 32'd10; ids[0] = 8'd1; sc[1] = 32'd20; ids[1] = 8'd2;
    lat = 20;
    rd_cnt = 0; sm_cnt = 0; exp_addr = 0;
    num_prev = 6'd2;
    threshold = 32'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("busy_before_reset", 128'(busy), 128'(1));
    reset_N = 1'b0;
    rem = 0;
    inflight = 1'b0;
    ram_pend = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    tick();
    tick();
    reset_N = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    sc[0] = 32'd42; ids[0] = 8'h11;
    run_search(1, 32'd50, 2, 32'd42, 8'h11, 1'b1, 1'b0, -1);

`ifdef OFLOW_SIM_DISPATCH_TIMEOUT_EN
    // Entry 1 never answers: skipped after TIMEOUT cycles, sticky error set.
    sc[0] = 32'd500; ids[0] = 8'd7;
    sc[1] = 32'd1;   ids[1] = 8'd9;
    sc[2] = 32'd300; ids[2] = 8'd4;
    drop_idx = 1;
    run_search(3, 32'd1000, 3, 32'd300, 8'd4, 1'b1, 1'b1, -1);
    drop_idx = -1;
    run_search(1, 32'd10, 1, 32'd500, 8'd7, 1'b0, 1'b0, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oflow_similarity_dispatcher.md
Name: oflow_similarity_dispatcher

Overview:
Initiator side of the similarity-metric interface. For one current-frame object, it walks the stored previous-frame feature table and launches one metric computation per entry. It collects each returned (score, id) pair and reports the best (minimum-score) match. It sits between the history feature RAM and the similarity metric unit and hands the best match to the ID-assignment stage.

Parameters:
MAX_PREV, 32, maximum number of previous-frame entries in the table
ADDR_LEN, 5, feature RAM address width (clog2 of MAX_PREV)
FEAT_LEN, 128, width of one previous-frame feature word
SCORE_LEN, 32, metric score width (unsigned; lower is a better match)
ID_LEN, 8, object ID width
TIMEOUT, 64, maximum cycles to wait for sm_valid (used only with the optional feature)

Ports:
clk  in  1  clock
reset_N  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a search for the current object
num_prev  in  ADDR_LEN+1  number of valid table entries (0..MAX_PREV), sampled on start
threshold  in  SCORE_LEN  maximum score accepted as a match, sampled on start
rd_en  out  1  feature RAM read enable
rd_addr  out  ADDR_LEN  feature RAM address
rd_data  in  FEAT_LEN  feature RAM data, valid 1 cycle after rd_en
sm_start  out  1  one-cycle pulse to the metric unit
sm_features_of_prev  out  FEAT_LEN  feature word for the metric unit, held stable from sm_start until sm_valid
sm_valid  in  1  metric result valid
sm_score  in  SCORE_LEN  metric score
sm_id  in  ID_LEN  ID of the compared previous object
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when the search completes
best_score  out  SCORE_LEN  minimum score found
best_id  out  ID_LEN  ID belonging to best_score
match_valid  out  1  best_score <= threshold and at least one entry was compared

Behaviour:
- Reset, asynchronous (reset_N=0): state IDLE. rd_en=0, rd_addr=0, sm_start=0, sm_features_of_prev=0, busy=0, done=0, best_score=all-ones, best_id=all-ones, match_valid=0. Reset mid-search aborts the search with no done pulse.
- State IDLE:
  - start=1 and num_prev>0: latch num_prev and threshold; idx=0; best_score=all-ones; best_id=all-ones; match_valid=0; go to READ.
  - start=1 and num_prev=0: go to FINISH directly (done with match_valid=0, best_* all-ones).
- State READ: rd_en=1, rd_addr=idx for exactly 1 cycle; go to LOAD.
- State LOAD: register rd_data into sm_features_of_prev; go to ISSUE.
- State ISSUE: sm_start=1 for 1 cycle; go to WAIT.
- State WAIT:
  - Hold sm_features_of_prev and rd_addr stable.
  - When sm_valid=1, capture sm_score and sm_id and go to CMP.
  - sm_valid in the same cycle as sm_start (i.e. in ISSUE) is ignored.
- State CMP:
  - If the captured score < best_score (strict), update best_score and best_id. Ties keep the earlier (lower-index) entry.
  - If idx == num_prev-1, go to FINISH; otherwise idx++ and go to READ.
- State FINISH: done=1 for 1 cycle; match_valid = (best_score <= threshold) && (num_prev != 0); busy=0; return to IDLE.
- best_score, best_id and match_valid hold their values until the next accepted start.
- busy=1 in every state except IDLE and FINISH.
- start is ignored while busy or in FINISH.
- Latency per entry: 4 cycles plus the metric latency L (READ, LOAD, ISSUE, CMP, plus L cycles in WAIT).
- Total latency from start to done: num_prev*(4+L)+1 cycles. With num_prev=0, done occurs 1 cycle after start.
- All comparisons are unsigned SCORE_LEN-bit. idx is ADDR_LEN+1 bits so a count of MAX_PREV does not wrap.

Optional Feature:
Macro: OFLOW_SIM_DISPATCH_TIMEOUT_EN
- Defined:
  - A WAIT-cycle counter is added.
  - If sm_valid is not seen within TIMEOUT cycles, the entry is skipped: treated as score all-ones, best is not updated, go to CMP.
  - A sticky output port timeout_err (1 bit) is set. It is cleared on the next accepted start and reset to 0.
- Undefined: no counter and no timeout_err port; WAIT waits indefinitely.

Test Plan:
- num_prev=3, scores 500/200/300, ids 7/9/4, threshold=250 -> done once; best_score=200, best_id=9, match_valid=1; three sm_start pulses; rd_addr sequence 0,1,2.
- num_prev=2, scores 100/100, ids 1/2 -> best_id=1 (tie keeps first entry); with threshold=99 -> match_valid=0.
- num_prev=0, start -> done exactly 1 cycle later; best_score=FFFFFFFF, best_id=FF, match_valid=0; no rd_en and no sm_start.
- num_prev=32, metric latency 10, start -> done at cycle 32*14+1=449; second start while busy is ignored; sm_features_of_prev stable throughout each WAIT.
- Reset_N asserted mid-WAIT, then released and num_prev=1 started -> outputs at reset values, no done from the aborted search; new search completes normally.
- With OFLOW_SIM_DISPATCH_TIMEOUT_EN and TIMEOUT=64: entry 1 of 3 never returns sm_valid -> after 64 cycles the entry is skipped; timeout_err=1; best is chosen from entries 0 and 2.
